// File: rtl/adc_volt_meter_pkg.sv
// adc_volt_pkg: shared types and helpers for the ADC voltmeter front end.
//   mode_e   : display mode selection (live / hold / min / max)
//   state_e  : calibration / run state of the front-end FSM
//   disp_t   : sign + magnitude (mV) pair as carried through the result path
//   acc_width: accumulator width that covers both calibration and averaging sums
//   signed_mv: sign + magnitude -> two's complement, used for min/max ordering
package adc_volt_pkg;

   typedef enum logic [1:0] {
      MODE_LIVE = 2'd0,
      MODE_HOLD = 2'd1,
      MODE_MIN  = 2'd2,
      MODE_MAX  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_CAL = 1'b0,
      ST_RUN = 1'b1
   } state_e;

   typedef struct packed {
      logic        neg;
      logic [15:0] mv;
   } disp_t;

   localparam disp_t DISP_ZERO = '{neg: 1'b0, mv: 16'd0};

   function automatic int acc_width(input int adc_w, input int cal_log2, input int avg_log2);
      return adc_w + ((cal_log2 > avg_log2) ? cal_log2 : avg_log2);
   endfunction

   // 18 bits hold -65535..+65535 without overflow
   function automatic logic signed [17:0] signed_mv(input disp_t d);
      logic signed [17:0] v;
      v = $signed({2'b00, d.mv});
      return d.neg ? -v : v;
   endfunction

endpackage

// File: rtl/adc_volt_meter_if.sv
// adc_volt_meter_if: ADC sample / control inputs and display outputs of the voltmeter.
//   slave  : the voltmeter (consumes ad_data/recal/mode, drives ad_clk and results)
//   master : the surrounding system (ADC model, mode switches, display driver)
interface adc_volt_meter_if #(parameter int ADC_W = 8);
   import adc_volt_pkg::*;

   logic [ADC_W-1:0] ad_data;
   logic             recal;
   mode_e            mode;
   logic             ad_clk;
   logic [15:0]      volt;
   logic             sign;
   logic             volt_vld;
   logic             cal_done;
   logic             ovr;

   modport slave (
      input  ad_data, recal, mode,
      output ad_clk, volt, sign, volt_vld, cal_done, ovr
   );

   modport master (
      output ad_data, recal, mode,
      input  ad_clk, volt, sign, volt_vld, cal_done, ovr
   );

endinterface

// File: rtl/adc_volt_meter_clk_gen.sv
// adc_clk_gen: divides sys_clk into the ADC conversion clock and flags the sample point.
//   sys_clk    in  system clock
//   sys_rst    in  asynchronous active-high reset
//   ad_clk_o   out ADC clock, half-period CLK_DIV sys_clk cycles, registered
//   samp_stb_o out one-cycle pulse starting on the edge where ad_clk_o falls
module adc_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic ad_clk_o,
   output logic samp_stb_o
);

   localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ad_clk_q, ad_clk_d;
   logic             stb_q, stb_d;

   // Divider next state: toggle at wrap; the strobe marks a 1->0 toggle
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d    = {CNT_W{1'b0}};
         ad_clk_d = ~ad_clk_q;
         stb_d    = ad_clk_q;
      end else begin
         cnt_d    = cnt_q + CNT_W'(1);
         ad_clk_d = ad_clk_q;
         stb_d    = 1'b0;
      end
   end

   // Divider registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q    <= {CNT_W{1'b0}};
         ad_clk_q <= 1'b0;
         stb_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ad_clk_q <= ad_clk_d;
         stb_q    <= stb_d;
      end
   end

   assign ad_clk_o   = ad_clk_q;
   assign samp_stb_o = stb_q;

endmodule

// File: rtl/adc_volt_meter.sv
// adc_volt_meter: ADC front end for the voltmeter.
//   Calibrates the zero (mid-scale) code, box-car averages 2^AVG_LOG2 samples,
//   scales to sign + magnitude mV through a 3-stage pipeline, tracks min/max and
//   drives a registered display mux (live / hold / min / max).
//   sys_clk in  system clock
//   sys_rst in  asynchronous active-high reset
//   bus     slave side of adc_volt_meter_if (ad_data, recal, mode -> ad_clk, volt,
//           sign, volt_vld, cal_done, ovr)
module adc_volt_meter
   import adc_volt_pkg::*;
#(
   parameter int ADC_W    = 8,
   parameter int CLK_DIV  = 2,
   parameter int CAL_LOG2 = 10,
   parameter int AVG_LOG2 = 4,
   parameter int SPAN_MV  = 10000
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   adc_volt_meter_if.slave bus
);

   localparam int                 LOG_MAX  = (CAL_LOG2 > AVG_LOG2) ? CAL_LOG2 : AVG_LOG2;
   localparam int                 ACC_W    = acc_width(ADC_W, CAL_LOG2, AVG_LOG2);
   localparam int                 PROD_W   = ADC_W + 33;
   localparam logic [LOG_MAX-1:0] CAL_LAST = LOG_MAX'((1 << CAL_LOG2) - 1);
   localparam logic [LOG_MAX-1:0] AVG_LAST = LOG_MAX'((1 << AVG_LOG2) - 1);

   logic               samp_stb_s, ad_clk_s;
   state_e             state_q, state_d;
   logic               cal_done_q, cal_done_d;
   logic               cal_fire_s, win_fire_s, last_s, clip_s;
   logic [LOG_MAX-1:0] cnt_q;
   logic [ACC_W-1:0]   acc_q, sum_s;
   logic               ovr_acc_q;
   logic [ADC_W-1:0]   mid_q;
   logic               s1_vld_q, s1_ovr_q;
   logic [ADC_W-1:0]   s1_avg_q;
   logic [ADC_W:0]     diff_s, s2_mag_q;
   logic               s2_vld_q, s2_neg_q, s2_ovr_q;
   logic [PROD_W-1:0]  prod_s, mv_full_s;
   logic [15:0]        mv_s;
   logic               s3_fire_s;
   disp_t              res_s, live_q, live_d, min_q, min_d, max_q, max_d;
   disp_t              hold_q, hold_d, disp_q, disp_d;
   logic               ext_vld_q, ext_vld_d;
   mode_e              mode_prev_q;
   logic               volt_vld_q, ovr_q;

   adc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .ad_clk_o   (ad_clk_s),
      .samp_stb_o (samp_stb_s)
   );

   assign sum_s  = acc_q + {{(ACC_W-ADC_W){1'b0}}, bus.ad_data};
   assign clip_s = (bus.ad_data == {ADC_W{1'b0}}) || (bus.ad_data == {ADC_W{1'b1}});
   assign diff_s = {1'b0, s1_avg_q} - {1'b0, mid_q};

   // FSM state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_CAL;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cal_done_q <= cal_done_d;
      end
   end

   // FSM next state: recal from any state restarts calibration
   always_comb begin
      state_d = state_q;
      if (bus.recal) begin
         state_d = ST_CAL;
      end else begin
         case (state_q)
            ST_CAL:  state_d = cal_fire_s ? ST_RUN : ST_CAL;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CAL;
         endcase
      end
   end

   // FSM outputs: closing-sample strobes per state (recal wins) and cal_done level
   always_comb begin
      cal_fire_s = 1'b0;
      win_fire_s = 1'b0;
      last_s     = 1'b0;
      case (state_q)
         ST_CAL: begin
            last_s     = (cnt_q == CAL_LAST);
            cal_fire_s = samp_stb_s && last_s && !bus.recal;
         end
         ST_RUN: begin
            last_s     = (cnt_q == AVG_LAST);
            win_fire_s = samp_stb_s && last_s && !bus.recal;
         end
         default: begin
            last_s     = 1'b0;
            cal_fire_s = 1'b0;
            win_fire_s = 1'b0;
         end
      endcase
      cal_done_d = (state_d == ST_RUN);
   end

   // Shared calibration/averaging accumulator, sample counter, clip flag and zero code
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         acc_q     <= {ACC_W{1'b0}};
         cnt_q     <= {LOG_MAX{1'b0}};
         ovr_acc_q <= 1'b0;
         mid_q     <= {1'b1, {(ADC_W-1){1'b0}}};
      end else begin
         if (bus.recal || cal_fire_s || win_fire_s) begin
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {LOG_MAX{1'b0}};
            ovr_acc_q <= 1'b0;
         end else if (samp_stb_s) begin
            acc_q     <= sum_s;
            cnt_q     <= cnt_q + LOG_MAX'(1);
            ovr_acc_q <= ovr_acc_q | clip_s;
         end
         if (cal_fire_s) begin
            mid_q <= sum_s[CAL_LOG2 +: ADC_W];
         end
      end
   end

   // S1 average / S2 signed difference; recal flushes anything in flight
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1_vld_q <= 1'b0;
         s1_avg_q <= {ADC_W{1'b0}};
         s1_ovr_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s2_neg_q <= 1'b0;
         s2_mag_q <= {(ADC_W+1){1'b0}};
         s2_ovr_q <= 1'b0;
      end else begin
         s1_vld_q <= win_fire_s;
         if (win_fire_s) begin
            s1_avg_q <= sum_s[AVG_LOG2 +: ADC_W];
            s1_ovr_q <= ovr_acc_q | clip_s;
         end
         s2_vld_q <= s1_vld_q && !bus.recal;
         s2_neg_q <= diff_s[ADC_W];
         s2_mag_q <= diff_s[ADC_W] ? (~diff_s + {{ADC_W{1'b0}}, 1'b1}) : diff_s;
         s2_ovr_q <= s1_ovr_q;
      end
   end

   // S3 scaling plus next values of live, min/max, hold and display mux
   always_comb begin
      prod_s    = PROD_W'(s2_mag_q) * PROD_W'(SPAN_MV);
      mv_full_s = prod_s >> ADC_W;
      if (|mv_full_s[PROD_W-1:16]) begin
         mv_s = 16'hFFFF;
      end else begin
         mv_s = mv_full_s[15:0];
      end
      // a zero result is always shown as +0 so +0/-0 compare equal
      res_s.mv  = mv_s;
      res_s.neg = s2_neg_q && (mv_s != 16'd0);
      s3_fire_s = s2_vld_q && !bus.recal;

      live_d = live_q;
      min_d  = min_q;
      max_d  = max_q;
      if (s3_fire_s) begin
         live_d = res_s;
         if (!ext_vld_q) begin
            min_d = res_s;
            max_d = res_s;
         end else begin
            if (signed_mv(res_s) < signed_mv(min_q)) begin
               min_d = res_s;
            end else begin
               min_d = min_q;
            end
            if (signed_mv(res_s) > signed_mv(max_q)) begin
               max_d = res_s;
            end else begin
               max_d = max_q;
            end
         end
      end else begin
         live_d = live_q;
      end

      if (bus.recal || cal_fire_s) begin
         ext_vld_d = 1'b0;
      end else if (s3_fire_s) begin
         ext_vld_d = 1'b1;
      end else begin
         ext_vld_d = ext_vld_q;
      end

      // hold snapshots the latest result on the cycle HOLD is entered
      if ((bus.mode == MODE_HOLD) && (mode_prev_q != MODE_HOLD)) begin
         hold_d = live_d;
      end else begin
         hold_d = hold_q;
      end

      disp_d = DISP_ZERO;
      case (bus.mode)
         MODE_LIVE: disp_d = live_d;
         MODE_HOLD: disp_d = hold_d;
         MODE_MIN:  disp_d = ext_vld_d ? min_d : DISP_ZERO;
         MODE_MAX:  disp_d = ext_vld_d ? max_d : DISP_ZERO;
         default:   disp_d = live_d;
      endcase
   end

   // Result, extreme-tracking and output registers; display frozen outside RUN
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         live_q      <= DISP_ZERO;
         min_q       <= DISP_ZERO;
         max_q       <= DISP_ZERO;
         hold_q      <= DISP_ZERO;
         disp_q      <= DISP_ZERO;
         ext_vld_q   <= 1'b0;
         mode_prev_q <= MODE_LIVE;
         volt_vld_q  <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         live_q      <= live_d;
         min_q       <= min_d;
         max_q       <= max_d;
         hold_q      <= hold_d;
         ext_vld_q   <= ext_vld_d;
         mode_prev_q <= bus.mode;
         volt_vld_q  <= s3_fire_s;
         if ((state_q == ST_RUN) && !bus.recal) begin
            disp_q <= disp_d;
         end
         if (s3_fire_s) begin
            ovr_q <= s2_ovr_q;
         end
      end
   end

   assign bus.ad_clk   = ad_clk_s;
   assign bus.volt     = disp_q.mv;
   assign bus.sign     = disp_q.neg;
   assign bus.volt_vld = volt_vld_q;
   assign bus.cal_done = cal_done_q;
   assign bus.ovr      = ovr_q;

endmodule
